// File: rtl/pipo_4bit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipo_4bit_if
//  Description : Bus bundle for the parallel-in/parallel-out holding register.
//                Carries the load strobe, the parallel input word and the
//                registered outputs. The optional parity output is present
//                only when PIPO_4BIT_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipo_4bit_if #(
  parameter int WIDTH = 4
);

  logic             load;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             loaded;
`ifdef PIPO_4BIT_PARITY_EN
  logic             pout_parity;
`endif

  // Producer side: drives the load strobe and data, observes the stored word.
  modport master (
    output load,
    output pin,
    input  pout,
`ifdef PIPO_4BIT_PARITY_EN
    input  pout_parity,
`endif
    input  loaded
  );

  // Register side: samples the load strobe and data, drives the stored word.
  modport slave (
    input  load,
    input  pin,
    output pout,
`ifdef PIPO_4BIT_PARITY_EN
    output pout_parity,
`endif
    output loaded
  );

endinterface
`default_nettype wire

// File: rtl/pipo_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : pipo_4bit
//  Description : Parallel-in/parallel-out holding register. Captures the whole
//                input word on a rising clk edge when load is high, otherwise
//                holds. A one-cycle 'loaded' pulse follows every capture.
//                Synchronous active-high reset has priority over load.
//                Optional feature macro: PIPO_4BIT_PARITY_EN adds a registered
//                even-parity output of the stored word.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipo_4bit #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  wire           clk,
  input  wire           rst,
  pipo_4bit_if.slave    bus
);

  // Parity of the reset word, so parity stays consistent with pout after reset.
  localparam logic C_RESET_PARITY = ^RESET_VALUE;

  logic [WIDTH-1:0] pout_q;
  logic [WIDTH-1:0] pout_d;
  logic             loaded_q;
  logic             loaded_d;

  // One 2:1 hold/load mux per bit feeding that bit's flip-flop; bit i of the
  // stored word always comes from bit i of pin, no reordering.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign pout_d[i] = bus.load ? bus.pin[i] : pout_q[i];
  end

  // The pulse is high exactly for the cycle after a capture.
  assign loaded_d = bus.load;

  // Stored word and load pulse; reset wins over any load in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pout_q   <= RESET_VALUE;
      loaded_q <= 1'b0;
    end else begin
      pout_q   <= pout_d;
      loaded_q <= loaded_d;
    end
  end

  assign bus.pout   = pout_q;
  assign bus.loaded = loaded_q;

`ifdef PIPO_4BIT_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity is computed from the next word so it updates on the same edge as
  // pout and never lags it by a cycle.
  assign parity_d = ^pout_d;

  // Registered even parity of the stored word.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= C_RESET_PARITY;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign bus.pout_parity = parity_q;
`else
  // Parity disabled: reference the constant so it is not left dangling.
  logic unused_reset_parity;
  assign unused_reset_parity = C_RESET_PARITY;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipo_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipo_4bit
//  Description : Directed self-checking bench for pipo_4bit. Inputs change
//                1 time unit after a rising edge; outputs are checked there.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipo_4bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  pipo_4bit_if #(.WIDTH(4)) bus ();

  pipo_4bit #(
    .WIDTH       (4),
    .RESET_VALUE (4'b0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check stored word and load pulse (and parity when present) together.
  task automatic expect_state(input string tag, input logic [3:0] w, input logic l);
    check({tag, ".pout"}, 64'(bus.pout), 64'(w));
    check({tag, ".loaded"}, 64'(bus.loaded), 64'(l));
`ifdef PIPO_4BIT_PARITY_EN
    check({tag, ".parity"}, 64'(bus.pout_parity), 64'(^w));
`endif
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.load = 1'b1;
    bus.pin  = 4'b1111;

    // 1. Reset beats a simultaneous load.
    tick();
    expect_state("reset", 4'b0000, 1'b0);

    // 2. Single load, then drop load.
    rst = 1'b0; bus.load = 1'b1; bus.pin = 4'b1011;
    tick();
    expect_state("load1", 4'b1011, 1'b1);

    // 3. Hold for three edges while pin wiggles.
    bus.load = 1'b0; bus.pin = 4'b0110;
    tick();
    expect_state("hold_a", 4'b1011, 1'b0);
    bus.pin = 4'b0001;
    tick();
    expect_state("hold_b", 4'b1011, 1'b0);
    bus.pin = 4'bxxxx;
    tick();
    expect_state("hold_c", 4'b1011, 1'b0);

    // 4. Back-to-back loads keep loaded high.
    bus.load = 1'b1; bus.pin = 4'b0110;
    tick();
    expect_state("reload_a", 4'b0110, 1'b1);
    bus.pin = 4'b1001;
    tick();
    expect_state("reload_b", 4'b1001, 1'b1);

    // 5. Mid-operation reset, with a load in the reset cycle that is lost.
    rst = 1'b1; bus.load = 1'b1; bus.pin = 4'b1111;
    tick();
    expect_state("midrst", 4'b0000, 1'b0);
    rst = 1'b0; bus.load = 1'b1; bus.pin = 4'b0101;
    tick();
    expect_state("postrst_load", 4'b0101, 1'b1);

    // Reloading the value already held still counts as a load.
    bus.pin = 4'b0101;
    tick();
    expect_state("same_val", 4'b0101, 1'b1);

    // Pulse drops once load is released; word holds.
    bus.load = 1'b0; bus.pin = 4'b1110;
    tick();
    expect_state("release", 4'b0101, 1'b0);

    // Bit ordering: single set bits map straight through.
    bus.load = 1'b1; bus.pin = 4'b1000;
    tick();
    expect_state("msb", 4'b1000, 1'b1);
    bus.pin = 4'b0001;
    tick();
    expect_state("lsb", 4'b0001, 1'b1);
    bus.pin = 4'b1111;
    tick();
    expect_state("ones", 4'b1111, 1'b1);

    // Reset with load low also clears.
    rst = 1'b1; bus.load = 1'b0;
    tick();
    expect_state("rst_idle", 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
